port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter_pkg.sv | 13 +
 rtl/rr_pick2.sv | 11 +
 rtl/port_arbiter.sv | 102 ++++++++++
 tb/tb_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/port_arbiter_pkg.sv
// Shared constants and FSM state encoding for the two-master ports-device arbiter.
package port_arbiter_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  assign winner = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/port_arbiter.sv
// Serialises CPU (0) and auxiliary (1) accesses onto a single ports device,
// one transaction at a time through IDLE -> SETUP -> STROBE -> DONE.
module port_arbiter
  import port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [WORD_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0] wdata0,
  output logic                 ack0,
  output logic [WORD_SIZE-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [WORD_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 ack1,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic [WORD_SIZE-1:0] portaddr,
  output logic [WORD_SIZE-1:0] portval,
  output logic                 portget,
  output logic                 portset,
  input  logic [WORD_SIZE-1:0] portout,
  output logic                 busy,
  output logic                 owner
);

  state_e               state_q, state_d;
  logic                 owner_q, last_q, we_q;
  logic                 ack0_q, ack1_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic                 winner, grant;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (winner)
  );

  assign grant = (state_q == ST_IDLE) && (req0 || req1);

  // NOTE: state_d gets its default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req0 || req1) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Ack is registered out of DONE, so it is seen in the following IDLE cycle.
      ack0_q  <= (state_q == ST_DONE) && !owner_q;
      ack1_q  <= (state_q == ST_DONE) &&  owner_q;
      if (grant) begin
        owner_q <= winner;
        we_q    <= winner ? we1    : we0;
        addr_q  <= winner ? addr1  : addr0;
        wdata_q <= winner ? wdata1 : wdata0;
      end
      if (state_q == ST_STROBE && !we_q) begin
        if (owner_q) rdata1_q <= portout;
        else         rdata0_q <= portout;
      end
      if (state_q == ST_DONE) last_q <= owner_q;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign portget  = (state_q == ST_STROBE) && !we_q;
  assign portset  = (state_q == ST_STROBE) &&  we_q;
  assign portaddr = addr_q;
  assign portval  = wdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed scoreboard bench for port_arbiter: transactions are queued when driven
// and retired against strobes and acks observed on the falling clock edge.
module tb_port_arbiter;

  localparam int W = 16;

  typedef struct {
    bit           owner;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
  } txn_t;

  logic         clk, reset;
  logic         req0, we0, req1, we1;
  logic [W-1:0] addr0, wdata0, addr1, wdata1;
  logic         ack0, ack1, portget, portset, busy, owner;
  logic [W-1:0] rdata0, rdata1, portaddr, portval, portout;
  logic [W-1:0] port_rd;

  txn_t         sb[$];
  int           n_checks, n_fail, n_acks, cyc, strobe_cnt, lat;
  bit           prev_ack;
  logic [W-1:0] rdata0_exp, rdata1_exp;
  int           ack_cyc[4];

  port_arbiter #(.WORD_SIZE(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .portaddr (portaddr),
    .portval  (portval),
    .portget  (portget),
    .portset  (portset),
    .portout  (portout),
    .busy     (busy),
    .owner    (owner)
  );

  // Ports device model: read data only appears while the read strobe is high.
  assign portout = portget ? port_rd : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    txn_t t;
    check("strobe_exclusive", {31'd0, portget & portset}, 0);
    if (portget || portset) begin
      check("strobe_implies_busy", {31'd0, busy}, 1);
      check("sb_nonempty_at_strobe", {31'd0, sb.size() > 0}, 1);
      if (sb.size() > 0) begin
        t = sb[0];
        strobe_cnt++;
        check("strobe_kind", {31'd0, portset}, {31'd0, t.we});
        check("strobe_owner", {31'd0, owner}, {31'd0, t.owner});
        check("strobe_addr", {16'd0, portaddr}, {16'd0, t.addr});
        if (t.we) check("strobe_val", {16'd0, portval}, {16'd0, t.wdata});
      end
    end
    if (ack0 || ack1) begin
      check("ack_exclusive", {31'd0, ack0 & ack1}, 0);
      check("ack_single_pulse", {31'd0, prev_ack}, 0);
      check("sb_nonempty_at_ack", {31'd0, sb.size() > 0}, 1);
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check("ack_owner", {31'd0, ack1}, {31'd0, t.owner});
        check("strobes_per_txn", strobe_cnt, 1);
        if (!t.we) begin
          if (t.owner) rdata1_exp = t.rdata;
          else         rdata0_exp = t.rdata;
        end
        check("rdata0", {16'd0, rdata0}, {16'd0, rdata0_exp});
        check("rdata1", {16'd0, rdata1}, {16'd0, rdata1_exp});
      end
      strobe_cnt = 0;
      n_acks++;
    end
    prev_ack = ack0 | ack1;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic wait_ack(input string tag, output int latency);
    int start_acks = n_acks;
    int start_cyc  = cyc;
    bit got        = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (n_acks != start_acks) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_ack_seen"}, {31'd0, got}, 1);
    latency = cyc - start_cyc;
  endtask

  task automatic push(input bit o, input bit we, input logic [W-1:0] a,
                      input logic [W-1:0] wd, input logic [W-1:0] rd);
    txn_t t;
    t.owner = o; t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd;
    sb.push_back(t);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_acks = 0; cyc = 0; strobe_cnt = 0; prev_ack = 1'b0;
    rdata0_exp = '0; rdata1_exp = '0; port_rd = '0;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset state
    cycle(); cycle();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_owner", {31'd0, owner}, 0);
    check("rst_acks", {30'd0, ack1, ack0}, 0);
    check("rst_strobes", {30'd0, portset, portget}, 0);
    check("rst_portaddr", {16'd0, portaddr}, 0);
    check("rst_portval", {16'd0, portval}, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    reset = 1'b0;
    cycle();
    check("idle_busy", {31'd0, busy}, 0);

    // Single write from requester 0: portset once, ack four cycles later
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd3; wdata0 = 16'h0055;
    push(1'b0, 1'b1, 16'd3, 16'h0055, '0);
    wait_ack("wr0", lat);
    req0 = 1'b0;
    check("wr0_latency", lat, 4);
    cycle();
    check("wr0_no_regrant", {31'd0, busy}, 0);

    // Read from requester 1: rdata1 captured, rdata0 untouched
    port_rd = 16'h1234;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd7; wdata1 = 16'hDEAD;
    push(1'b1, 1'b0, 16'd7, 16'hDEAD, 16'h1234);
    wait_ack("rd1", lat);
    req1 = 1'b0;
    check("rd1_latency", lat, 4);
    check("rd1_rdata1", {16'd0, rdata1}, 32'h1234);
    check("rd1_rdata0_kept", {16'd0, rdata0}, 0);
    cycle();

    // Both held for four transactions: grants alternate 0,1,0,1 every 4 cycles
    port_rd = 16'h5A5A;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0021; wdata0 = 16'hAAAA;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0022;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b1, 16'h0021, 16'hAAAA, '0);
      push(1'b1, 1'b0, 16'h0022, '0, 16'h5A5A);
    end
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr", lat);
      ack_cyc[i] = cyc;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 1; i < 4; i++) check("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
    check("rr_sb_drained", sb.size(), 0);
    cycle();
    check("rr_idle_after", {31'd0, busy}, 0);

    // Requester 0 drops req during SETUP: transaction still completes
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd9; wdata0 = 16'h0099;
    push(1'b0, 1'b1, 16'd9, 16'h0099, '0);
    cycle();
    check("drop_in_setup_busy", {31'd0, busy}, 1);
    req0 = 1'b0;
    wait_ack("drop", lat);
    check("drop_latency", lat, 3);
    cycle();

    // Reset during STROBE: strobes fall at once, no ack, requester 0 wins after release
    port_rd = 16'hBEEF;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h3333;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd5;
    push(1'b1, 1'b0, 16'd5, '0, 16'hBEEF);
    cycle();
    check("abort_owner", {31'd0, owner}, 1);
    cycle();
    check("abort_in_strobe", {31'd0, portget}, 1);
    reset = 1'b1;
    #1;
    check("abort_strobes_drop", {30'd0, portset, portget}, 0);
    check("abort_busy_drop", {31'd0, busy}, 0);
    sb.delete();
    strobe_cnt = 0;
    rdata0_exp = '0; rdata1_exp = '0;
    cycle(); cycle();
    check("abort_no_ack", {30'd0, ack1, ack0}, 0);
    reset = 1'b0;
    push(1'b0, 1'b1, 16'h0030, 16'h3333, '0);
    push(1'b1, 1'b0, 16'd5, '0, 16'hBEEF);
    cycle();
    check("post_reset_owner", {31'd0, owner}, 0);
    wait_ack("post_reset0", lat);
    wait_ack("post_reset1", lat);
    req0 = 1'b0; req1 = 1'b0;
    check("post_reset1_spacing", lat, 4);
    cycle(); cycle();
    check("final_idle", {31'd0, busy}, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
